// File: rtl/vga_pkg.sv
// Shared VGA display-path constants and the pixel class tag.
package vga_pkg;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int IMG_DIM  = 256;

    typedef enum logic [1:0] {
        TAG_BG     = 2'd0,
        TAG_WIN    = 2'd1,
        TAG_BORDER = 2'd2
    } pix_tag_t;
endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with a configurable reset value.
module vga_delay_line #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign dout = stages[DEPTH-1];
endmodule

// File: rtl/vga_pixel_fetch.sv
// Fetches a 256x256 grayscale window from a double-buffered framebuffer and
// drives the DAC with latency-matched syncs. Optional border: VGA_BORDER_EN.
import vga_pkg::*;

module vga_pixel_fetch #(
    parameter int         X0           = 192,
    parameter int         Y0           = 112,
    parameter int         MEM_LAT      = 1,
    parameter logic [7:0] BG_COLOR     = 8'h00,
    parameter logic [7:0] BORDER_COLOR = 8'hFF
) (
    input  logic        clk_25,
    input  logic        rst_n,
    input  logic [9:0]  hs,
    input  logic [9:0]  vs,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic        sync_blank,
    output logic        mem_rd,
    output logic [16:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        fb_sel,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync_o,
    output logic        vga_vsync_o,
    output logic        vga_blank_n,
    output logic        vga_sync_n
);
    localparam logic [9:0] X0_V = 10'(X0);
    localparam logic [9:0] Y0_V = 10'(Y0);

    // Unsigned wrap makes coordinates left/above the origin fail the test.
    logic [9:0] dx, dy;
    logic       in_win;
    assign dx     = hs - X0_V;
    assign dy     = vs - Y0_V;
    assign in_win = (dx < 10'(IMG_DIM)) && (dy < 10'(IMG_DIM));

    pix_tag_t tag_c;
`ifdef VGA_BORDER_EN
    localparam logic [9:0] BX0 = 10'(X0 - 1);
    localparam logic [9:0] BY0 = 10'(Y0 - 1);
    logic [9:0] bx, by;
    logic       ring;
    assign bx   = hs - BX0;
    assign by   = vs - BY0;
    assign ring = (bx <= 10'(IMG_DIM + 1)) && (by <= 10'(IMG_DIM + 1));
`endif

    always_comb begin
        tag_c = TAG_BG;
        if (in_win) tag_c = TAG_WIN;
`ifdef VGA_BORDER_EN
        else if (ring) tag_c = TAG_BORDER;
`endif
    end

    logic [1:0] tag_a;
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            tag_a    <= TAG_BG;
        end else begin
            mem_rd <= in_win;
            tag_a  <= tag_c;
            if (in_win) mem_addr <= {fb_sel, dy[7:0], dx[7:0]};
        end
    end

    logic [1:0] tag_d;
    vga_delay_line #(.DEPTH(MEM_LAT), .WIDTH(2), .RST_VAL(TAG_BG)) u_tag_dl (
        .clk(clk_25), .rst_n(rst_n), .din(tag_a), .dout(tag_d)
    );

    // Syncs go straight to the pins; blank stops one stage short so it can
    // gate the rgb register that shares its final stage.
    logic [1:0] sync_d;
    vga_delay_line #(.DEPTH(2 + MEM_LAT), .WIDTH(2), .RST_VAL(2'b11)) u_sync_dl (
        .clk(clk_25), .rst_n(rst_n), .din({vga_hsync, vga_vsync}), .dout(sync_d)
    );

    logic blank_pre;
    vga_delay_line #(.DEPTH(1 + MEM_LAT), .WIDTH(1), .RST_VAL(1'b1)) u_blank_dl (
        .clk(clk_25), .rst_n(rst_n), .din(sync_blank), .dout(blank_pre)
    );

    logic [7:0] gray;
    logic       blank_q;
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            gray    <= 8'h00;
            blank_q <= 1'b1;
        end else begin
            blank_q <= blank_pre;
            if (blank_pre) gray <= 8'h00;
            else begin
                case (pix_tag_t'(tag_d))
                    TAG_WIN:    gray <= mem_rdata;
                    TAG_BORDER: gray <= BORDER_COLOR;
                    default:    gray <= BG_COLOR;
                endcase
            end
        end
    end

    // Flip only at the first blank line, so the displayed buffer never tears.
    logic frame_start;
    assign frame_start = (hs == 10'd0) && (vs == 10'(V_ACTIVE));

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            fb_sel   <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            if (frame_start && swap_req) begin
                fb_sel   <= ~fb_sel;
                swap_ack <= 1'b1;
            end
        end
    end

    assign vga_r       = gray;
    assign vga_g       = gray;
    assign vga_b       = gray;
    assign vga_hsync_o = sync_d[1];
    assign vga_vsync_o = sync_d[0];
    assign vga_blank_n = ~blank_q;
    assign vga_sync_n  = 1'b0;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed table-driven bench for vga_pixel_fetch with a latency-matched RAM model.
module tb_vga_pixel_fetch;
    localparam int LAT = 1;
`ifdef VGA_BORDER_EN
    localparam logic [7:0] BRD = 8'hFF;
`else
    localparam logic [7:0] BRD = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hs, vs;
    logic        hsync, vsync, blank;
    logic        mem_rd;
    logic [16:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        swap_req, swap_ack, fb_sel;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        hso, vso, blank_n, sync_n;

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    vga_pixel_fetch #(.MEM_LAT(LAT)) dut (
        .clk_25(clk), .rst_n(rst_n), .hs(hs), .vs(vs),
        .vga_hsync(hsync), .vga_vsync(vsync), .sync_blank(blank),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .swap_req(swap_req), .swap_ack(swap_ack), .fb_sel(fb_sel),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync_o(hso), .vga_vsync_o(vso), .vga_blank_n(blank_n),
        .vga_sync_n(sync_n)
    );

    // RAM contents: col + 2*row + 5A, plus 40 for buffer 1.
    function automatic logic [7:0] ram_f(input logic [16:0] a);
        return a[7:0] + {a[14:8], 1'b0} + 8'h5A + (a[16] ? 8'h40 : 8'h00);
    endfunction

    logic [LAT-1:0][7:0] ram_pipe;
    always_ff @(posedge clk) begin
        ram_pipe[0] <= mem_rd ? ram_f(mem_addr) : 8'hEE;
        for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign mem_rdata = ram_pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v,
                         input logic hy, input logic vy, input logic bk);
        hs = h; vs = v; hsync = hy; vsync = vy; blank = bk;
    endtask

    task automatic chk_rgb(input string name, input logic [7:0] exp);
        chk({name, "_r"}, vga_r, exp);
        chk({name, "_g"}, vga_g, exp);
        chk({name, "_b"}, vga_b, exp);
    endtask

    typedef struct {
        logic [9:0]  hs, vs;
        logic        hy, vy, bk;
        logic        rd;
        logic [16:0] addr;
        logic [7:0]  rgb;
        logic        hso, vso, bn;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{10'd192,  10'd112, 1, 1, 0, 1, 17'h00000, 8'h5A, 1, 1, 1};
        tbl[1]  = '{10'd447,  10'd367, 1, 1, 0, 1, 17'h0FFFF, 8'h57, 1, 1, 1};
        tbl[2]  = '{10'd300,  10'd200, 1, 1, 0, 1, 17'h0586C, 8'h76, 1, 1, 1};
        tbl[3]  = '{10'd191,  10'd150, 1, 1, 0, 0, 17'h0586C, BRD,   1, 1, 1};
        tbl[4]  = '{10'd448,  10'd200, 1, 1, 0, 0, 17'h0586C, BRD,   1, 1, 1};
        tbl[5]  = '{10'd300,  10'd111, 1, 1, 0, 0, 17'h0586C, BRD,   1, 1, 1};
        tbl[6]  = '{10'd190,  10'd150, 1, 1, 0, 0, 17'h0586C, 8'h00, 1, 1, 1};
        tbl[7]  = '{10'd1000, 10'd200, 1, 1, 0, 0, 17'h0586C, 8'h00, 1, 1, 1};
        tbl[8]  = '{10'd192,  10'd367, 1, 1, 0, 1, 17'h0FF00, 8'h58, 1, 1, 1};
        tbl[9]  = '{10'd700,  10'd200, 0, 1, 1, 0, 17'h0FF00, 8'h00, 0, 1, 0};
        tbl[10] = '{10'd300,  10'd500, 1, 0, 1, 0, 17'h0FF00, 8'h00, 1, 0, 0};

        rst_n = 1'b0; swap_req = 1'b0;
        drive(10'd700, 10'd500, 1, 1, 1);
        tick(); tick();
        chk("rst_rgb", vga_r, 8'h00);
        chk("rst_hso", hso, 1'b1);
        chk("rst_vso", vso, 1'b1);
        chk("rst_bn", blank_n, 1'b0);
        chk("rst_rd", mem_rd, 1'b0);
        chk("rst_addr", mem_addr, 17'h0);
        chk("rst_fb", fb_sel, 1'b0);
        chk("rst_ack", swap_ack, 1'b0);
        chk("sync_n", sync_n, 1'b0);
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].hs, tbl[i].vs, tbl[i].hy, tbl[i].vy, tbl[i].bk);
            tick();
            chk($sformatf("v%0d_rd", i), mem_rd, tbl[i].rd);
            chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].addr);
            for (int k = 0; k <= LAT; k++) tick();
            chk_rgb($sformatf("v%0d_rgb", i), tbl[i].rgb);
            chk($sformatf("v%0d_hso", i), hso, tbl[i].hso);
            chk($sformatf("v%0d_vso", i), vso, tbl[i].vso);
            chk($sformatf("v%0d_bn", i), blank_n, tbl[i].bn);
        end

        // Mid-line async reset, then exact latency of the first pixel.
        drive(10'd300, 10'd200, 1, 1, 0);
        for (int k = 0; k < 4; k++) tick();
        chk_rgb("pre_rst", 8'h76);
        rst_n = 1'b0;
        #1;
        chk_rgb("mid_rst", 8'h00);
        chk("mid_rst_bn", blank_n, 1'b0);
        chk("mid_rst_rd", mem_rd, 1'b0);
        chk("mid_rst_addr", mem_addr, 17'h0);
        for (int k = 0; k < 5; k++) tick();
        chk("hold_rst_bn", blank_n, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 1 + LAT; k++) tick();
        chk("rel_early_bn", blank_n, 1'b0);
        chk_rgb("rel_early", 8'h00);
        chk("rel_early_hso", hso, 1'b1);
        tick();
        chk("rel_bn", blank_n, 1'b1);
        chk_rgb("rel", 8'h76);

        // hsync fall and blank rise reach the pins after exactly 2+LAT cycles.
        drive(10'd400, 10'd200, 1, 1, 0);
        for (int k = 0; k < 4; k++) tick();
        chk_rgb("hs_pre", 8'hDA);
        drive(10'd656, 10'd200, 0, 1, 1);
        for (int k = 0; k < 1 + LAT; k++) tick();
        chk("hs_early_hso", hso, 1'b1);
        chk("hs_early_bn", blank_n, 1'b1);
        chk_rgb("hs_early", 8'hDA);
        tick();
        chk("hs_hso", hso, 1'b0);
        chk("hs_bn", blank_n, 1'b0);
        chk_rgb("hs_blank", 8'h00);

        // Swap: request ignored except at frame start.
        drive(10'd200, 10'd200, 1, 1, 0);
        swap_req = 1'b1;
        tick(); tick();
        chk("swap_mid_fb", fb_sel, 1'b0);
        chk("swap_mid_ack", swap_ack, 1'b0);
        drive(10'd0, 10'd479, 1, 1, 0);
        tick();
        chk("swap_479_fb", fb_sel, 1'b0);
        drive(10'd0, 10'd480, 1, 1, 1);
        tick();
        chk("swap_fb", fb_sel, 1'b1);
        chk("swap_ack", swap_ack, 1'b1);
        drive(10'd1, 10'd480, 1, 1, 1);
        tick();
        chk("swap_ack_drop", swap_ack, 1'b0);
        chk("swap_fb_hold", fb_sel, 1'b1);
        swap_req = 1'b0;
        drive(10'd0, 10'd480, 1, 1, 1);
        tick();
        chk("noswap_fb", fb_sel, 1'b1);
        chk("noswap_ack", swap_ack, 1'b0);
        drive(10'd447, 10'd367, 1, 1, 0);
        tick();
        chk("fb1_addr", mem_addr, 17'h1FFFF);
        for (int k = 0; k <= LAT; k++) tick();
        chk_rgb("fb1_rgb", 8'h97);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
